// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared encodings for the machine-mode trap sequencer
package trap_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_BREAK     = 4'd3;
  localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;

  typedef enum logic {
    MEPC_PC_EXEC,
    MEPC_PC_MEM
  } mepc_sel_e;

  typedef enum logic [2:0] {
    MTVAL_ZERO,
    MTVAL_LDST,
    MTVAL_JUMP,
    MTVAL_INSTR,
    MTVAL_PC
  } mtval_sel_e;

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - single-winner priority encoder over trap requests
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic       ldst_i,
  input  logic       jump_i,
  input  logic       illegal_i,
  input  logic       ebreak_i,
  input  logic       ecall_i,
  input  logic       mret_i,
  input  logic       is_store_i,
  output logic       exc_valid_o,
  output logic       mret_valid_o,
  output logic [3:0] cause_o,
  output mepc_sel_e  mepc_sel_o,
  output mtval_sel_e mtval_sel_o
);

  always_comb begin
    exc_valid_o = 1'b1;
    cause_o     = CAUSE_ECALL_M;
    mepc_sel_o  = MEPC_PC_EXEC;
    mtval_sel_o = MTVAL_ZERO;
    // MEM-stage fault wins because that instruction is older than EXE
    if (ldst_i) begin
      cause_o     = is_store_i ? CAUSE_SMISALIGN : CAUSE_LMISALIGN;
      mepc_sel_o  = MEPC_PC_MEM;
      mtval_sel_o = MTVAL_LDST;
    end else if (jump_i) begin
      cause_o     = CAUSE_IMISALIGN;
      mtval_sel_o = MTVAL_JUMP;
    end else if (illegal_i) begin
      cause_o     = CAUSE_ILLEGAL;
      mtval_sel_o = MTVAL_INSTR;
    end else if (ebreak_i) begin
      cause_o     = CAUSE_BREAK;
      mtval_sel_o = MTVAL_PC;
    end else if (!ecall_i) begin
      exc_valid_o = 1'b0;
    end
    mret_valid_o = mret_i && !exc_valid_o;
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry / MRET sequencer: flush, CSR commit, fetch redirect
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int SIZE         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            misaligned_jump_exception,
  input  logic            misaligned_ldst_exception,
  input  logic            ldst_is_store,
  input  logic            illegal_instr,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            mret,
  input  logic [SIZE-1:0] PC_exec,
  input  logic [SIZE-1:0] PC_MEM,
  input  logic [SIZE-1:0] jump_address,
  input  logic [SIZE-1:0] ldst_address,
  input  logic [SIZE-1:0] instr_word,
  input  logic [SIZE-1:0] mtvec_address,
  input  logic [SIZE-1:0] mepc_in,
  output logic            flush,
  output logic            stall,
  output logic            trap_csr_we,
  output logic [SIZE-1:0] trap_mepc,
  output logic [SIZE-1:0] trap_mcause,
  output logic [SIZE-1:0] trap_mtval,
  output logic            pc_redirect_valid,
  output logic [SIZE-1:0] pc_redirect,
  output logic            busy
);

  localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [SIZE-1:0] ALIGN_MASK = {{(SIZE-2){1'b1}}, 2'b00};

  logic            exc_valid, mret_valid;
  logic [3:0]      cause;
  mepc_sel_e       mepc_sel;
  mtval_sel_e      mtval_sel;

  logic [1:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [SIZE-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [SIZE-1:0] redir_q, redir_d;

  trap_prio_enc u_prio (
    .ldst_i       (misaligned_ldst_exception),
    .jump_i       (misaligned_jump_exception),
    .illegal_i    (illegal_instr),
    .ebreak_i     (ebreak),
    .ecall_i      (ecall),
    .mret_i       (mret),
    .is_store_i   (ldst_is_store),
    .exc_valid_o  (exc_valid),
    .mret_valid_o (mret_valid),
    .cause_o      (cause),
    .mepc_sel_o   (mepc_sel),
    .mtval_sel_o  (mtval_sel)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    redir_d  = redir_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          state_d  = ST_FLUSH;
          cnt_d    = FLUSH_LOAD;
          mepc_d   = (mepc_sel == MEPC_PC_MEM) ? PC_MEM : PC_exec;
          mcause_d = {{(SIZE-4){1'b0}}, cause};
          case (mtval_sel)
            MTVAL_LDST:  mtval_d = ldst_address;
            MTVAL_JUMP:  mtval_d = jump_address;
            MTVAL_INSTR: mtval_d = instr_word;
            MTVAL_PC:    mtval_d = PC_exec;
            default:     mtval_d = '0;
          endcase
        end else if (mret_valid) begin
          state_d = ST_REDIRECT;
          redir_d = mepc_in & ALIGN_MASK;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
        redir_d = mtvec_address & ALIGN_MASK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      redir_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      redir_q  <= redir_d;
    end
  end

  // Flush in the accepting cycle so the faulting instruction never retires
  assign flush = (state_q != ST_IDLE) || (!reset && (exc_valid || mret_valid));
  assign stall = (state_q == ST_FLUSH) || (state_q == ST_COMMIT);
  assign trap_csr_we       = (state_q == ST_COMMIT);
  assign pc_redirect_valid = (state_q == ST_REDIRECT);
  assign busy              = (state_q != ST_IDLE);
  assign trap_mepc         = mepc_q;
  assign trap_mcause       = mcause_q;
  assign trap_mtval        = mtval_q;
  assign pc_redirect       = redir_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized check of trap_ctrl (FLUSH_CYCLES 2 and 1) against an event-timeline model
module tb_trap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, jmp, ldst, st, ill, ecl, ebk, mrt;
  logic [31:0] pc_exec, pc_mem, jaddr, laddr, iword, mtvec, mepc_in;

  logic [1:0]  flush_w, stall_w, we_w, rv_w, busy_w;
  logic [31:0] mepc_w [2];
  logic [31:0] mcause_w [2];
  logic [31:0] mtval_w [2];
  logic [31:0] redir_w [2];

  trap_ctrl #(.SIZE(32), .FLUSH_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(rst),
    .misaligned_jump_exception(jmp), .misaligned_ldst_exception(ldst),
    .ldst_is_store(st), .illegal_instr(ill), .ecall(ecl), .ebreak(ebk), .mret(mrt),
    .PC_exec(pc_exec), .PC_MEM(pc_mem), .jump_address(jaddr), .ldst_address(laddr),
    .instr_word(iword), .mtvec_address(mtvec), .mepc_in(mepc_in),
    .flush(flush_w[0]), .stall(stall_w[0]), .trap_csr_we(we_w[0]),
    .trap_mepc(mepc_w[0]), .trap_mcause(mcause_w[0]), .trap_mtval(mtval_w[0]),
    .pc_redirect_valid(rv_w[0]), .pc_redirect(redir_w[0]), .busy(busy_w[0])
  );

  trap_ctrl #(.SIZE(32), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst),
    .misaligned_jump_exception(jmp), .misaligned_ldst_exception(ldst),
    .ldst_is_store(st), .illegal_instr(ill), .ecall(ecl), .ebreak(ebk), .mret(mrt),
    .PC_exec(pc_exec), .PC_MEM(pc_mem), .jump_address(jaddr), .ldst_address(laddr),
    .instr_word(iword), .mtvec_address(mtvec), .mepc_in(mepc_in),
    .flush(flush_w[1]), .stall(stall_w[1]), .trap_csr_we(we_w[1]),
    .trap_mepc(mepc_w[1]), .trap_mcause(mcause_w[1]), .trap_mtval(mtval_w[1]),
    .pc_redirect_valid(rv_w[1]), .pc_redirect(redir_w[1]), .busy(busy_w[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Model: each accepted event is a timeline indexed by its age in cycles
  int          fl[2] = '{2, 1};
  bit          m_act[2], m_mret[2];
  int          m_age[2];
  logic [31:0] m_mepc[2], m_mcause[2], m_mtval[2], m_redir[2];

  task automatic winner(output bit v, output logic [31:0] pc, output logic [31:0] cs,
                        output logic [31:0] tv);
    v = 1'b1; pc = pc_exec; cs = 32'd11; tv = 32'd0;
    if (ldst) begin pc = pc_mem; cs = st ? 32'd6 : 32'd4; tv = laddr; end
    else if (jmp) begin cs = 32'd0; tv = jaddr; end
    else if (ill) begin cs = 32'd2; tv = iword; end
    else if (ebk) begin cs = 32'd3; tv = pc_exec; end
    else if (!ecl) v = 1'b0;
  endtask

  task automatic check_dut(input int i);
    bit v; logic [31:0] pc, cs, tv;
    bit e_fl, e_st, e_we, e_rv;
    winner(v, pc, cs, tv);
    e_fl = 0; e_st = 0; e_we = 0; e_rv = 0;
    if (!m_act[i]) e_fl = !rst && (v || mrt);
    else if (m_mret[i]) begin e_fl = 1; e_rv = 1; end
    else begin
      e_fl = 1;
      e_st = (m_age[i] <= fl[i] + 1);
      e_we = (m_age[i] == fl[i] + 1);
      e_rv = (m_age[i] == fl[i] + 2);
    end
    check($sformatf("d%0d flush", i), flush_w[i], e_fl);
    check($sformatf("d%0d stall", i), stall_w[i], e_st);
    check($sformatf("d%0d csr_we", i), we_w[i], e_we);
    check($sformatf("d%0d redirect_valid", i), rv_w[i], e_rv);
    check($sformatf("d%0d busy", i), busy_w[i], m_act[i]);
    check($sformatf("d%0d mepc", i), mepc_w[i], m_mepc[i]);
    check($sformatf("d%0d mcause", i), mcause_w[i], m_mcause[i]);
    check($sformatf("d%0d mtval", i), mtval_w[i], m_mtval[i]);
    check($sformatf("d%0d pc_redirect", i), redir_w[i], m_redir[i]);
  endtask

  task automatic model_edge(input int i);
    bit v; logic [31:0] pc, cs, tv;
    winner(v, pc, cs, tv);
    if (rst) begin
      m_act[i] = 0; m_mret[i] = 0; m_age[i] = 0;
      m_mepc[i] = 0; m_mcause[i] = 0; m_mtval[i] = 0; m_redir[i] = 0;
    end else if (!m_act[i]) begin
      if (v) begin
        m_act[i] = 1; m_mret[i] = 0; m_age[i] = 1;
        m_mepc[i] = pc; m_mcause[i] = cs; m_mtval[i] = tv;
      end else if (mrt) begin
        m_act[i] = 1; m_mret[i] = 1; m_age[i] = 1;
        m_redir[i] = mepc_in & ~32'h3;
      end
    end else if ((m_mret[i] && m_age[i] == 1) || (!m_mret[i] && m_age[i] == fl[i] + 2)) begin
      m_act[i] = 0;
    end else begin
      m_age[i]++;
      if (!m_mret[i] && m_age[i] == fl[i] + 2) m_redir[i] = mtvec & ~32'h3;
    end
  endtask

  // Inputs are driven at posedge+1; outputs checked at negedge; model advances at posedge+1
  task automatic step();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
  endtask

  task automatic clr_req();
    jmp = 0; ldst = 0; st = 0; ill = 0; ecl = 0; ebk = 0; mrt = 0;
  endtask

  initial begin
    rst = 1; clr_req();
    pc_exec = 0; pc_mem = 0; jaddr = 0; laddr = 0; iword = 0; mtvec = 0; mepc_in = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_mret[i] = 0; m_age[i] = 0;
      m_mepc[i] = 0; m_mcause[i] = 0; m_mtval[i] = 0; m_redir[i] = 0;
    end
    step();
    rst = 0;
    repeat (10) step();

    mtvec = 32'h203; pc_exec = 32'h100; ecl = 1;
    step(); clr_req();
    repeat (5) step();
    check("ecall mepc", mepc_w[0], 32'h100);
    check("ecall mcause", mcause_w[0], 32'd11);
    check("ecall redirect", redir_w[0], 32'h200);

    pc_mem = 32'h40; pc_exec = 32'h44; laddr = 32'h1002; ldst = 1; ill = 1; st = 0;
    step(); clr_req();
    repeat (5) step();
    check("lmis mepc", mepc_w[0], 32'h40);
    check("lmis mcause", mcause_w[0], 32'd4);
    check("lmis mtval", mtval_w[0], 32'h1002);

    mepc_in = 32'h87; mrt = 1;
    step(); clr_req();
    repeat (3) step();
    check("mret redirect", redir_w[0], 32'h84);

    jaddr = 32'h302; jmp = 1;
    step(); clr_req(); ecl = 1;
    step(); clr_req();
    repeat (5) step();
    check("jump mcause", mcause_w[0], 32'd0);
    check("jump mtval", mtval_w[0], 32'h302);

    pc_exec = 32'h500; ecl = 1;
    step(); clr_req();
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    check("abort busy", busy_w[0], 1'b0);
    check("abort mepc", mepc_w[0], 32'h0);
    ecl = 1;
    step(); clr_req();
    repeat (5) step();

    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      ldst = ($urandom_range(0, 9) == 0);
      jmp  = ($urandom_range(0, 9) == 0);
      ill  = ($urandom_range(0, 9) == 0);
      ebk  = ($urandom_range(0, 9) == 0);
      ecl  = ($urandom_range(0, 9) == 0);
      mrt  = ($urandom_range(0, 7) == 0);
      st   = 1'($urandom);
      pc_exec = $urandom; pc_mem = $urandom; jaddr = $urandom; laddr = $urandom;
      iword = $urandom; mepc_in = $urandom;
      if (!m_act[0] && !m_act[1]) mtvec = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and MRET return for the 5-stage core.
- Arbitrates simultaneous exception sources from the EXE and MEM stages, then freezes and flushes the pipeline.
- Produces a single registered CSR update (mepc/mcause/mtval) and redirects fetch to mtvec, or to mepc on MRET.
- Sits beside EXE; its CSR strobe feeds the EXE CSR file, and its redirect feeds the IF PC mux.

Parameters:
- SIZE, 32, datapath width.
- FLUSH_CYCLES, 2, cycles of pipeline freeze before CSR commit; legal range 1..7.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- misaligned_jump_exception  in  1  EXE-stage jump target misaligned.
- misaligned_ldst_exception  in  1  MEM-stage load/store address misaligned.
- ldst_is_store  in  1  qualifies the ldst exception: 1 = store, 0 = load.
- illegal_instr  in  1  EXE-stage illegal instruction.
- ecall  in  1  EXE-stage ECALL.
- ebreak  in  1  EXE-stage EBREAK.
- mret  in  1  EXE-stage MRET.
- PC_exec  in  SIZE  PC of the EXE instruction.
- PC_MEM  in  SIZE  PC of the MEM instruction.
- jump_address  in  SIZE  faulting jump target.
- ldst_address  in  SIZE  faulting effective address.
- instr_word  in  SIZE  EXE instruction encoding.
- mtvec_address  in  SIZE  trap vector from the CSR file.
- mepc_in  in  SIZE  current mepc.
- flush  out  1  kill IF/ID/EXE/MEM contents.
- stall  out  1  freeze the PC and pipeline registers.
- trap_csr_we  out  1  one-cycle strobe that writes mepc, mcause and mtval together.
- trap_mepc  out  SIZE  value written to mepc.
- trap_mcause  out  SIZE  value written to mcause.
- trap_mtval  out  SIZE  value written to mtval.
- pc_redirect_valid  out  1  one-cycle fetch redirect.
- pc_redirect  out  SIZE  redirect target.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- States: IDLE, FLUSH, COMMIT, REDIRECT.
- Reset: state goes to IDLE and the flush counter clears. All outputs are 0 in the cycle after reset is sampled. Reset mid-sequence aborts the sequence: no CSR strobe and no redirect are issued.

Priority (single winner, evaluated in IDLE only):
- misaligned_ldst_exception is highest, because the MEM instruction is older.
- Then misaligned_jump_exception, then illegal_instr, then ebreak, then ecall.
- mret is accepted only when no exception is present in the same cycle.

Capture per winner (mepc / mcause / mtval):
- ldst store: PC_MEM / 6 / ldst_address.
- ldst load: PC_MEM / 4 / ldst_address.
- jump: PC_exec / 0 / jump_address.
- illegal: PC_exec / 2 / instr_word.
- ebreak: PC_exec / 3 / PC_exec.
- ecall: PC_exec / 11 / 0.
- mcause[SIZE-1] (interrupt bit) is always 0.
- Captured values are held in registers until the next accepted event.

Exception sequence:
- Cycle T (IDLE, winner present): flush=1 combinationally, so the faulting instruction never writes back. Values are captured, and the next state is FLUSH.
- FLUSH: stall=1, flush=1 for exactly FLUSH_CYCLES cycles, using a down-counter loaded at T.
- COMMIT: one cycle. trap_csr_we=1, stall=1, flush=1, trap_* outputs valid.
- REDIRECT: one cycle. pc_redirect_valid=1, pc_redirect={mtvec_address[SIZE-1:2],2'b00}, flush=1, stall=0. Next state is IDLE.
- Redirect pulse occurs at T+FLUSH_CYCLES+2.

MRET sequence:
- Cycle T (IDLE, mret, no exception): flush=1. Next state is REDIRECT with pc_redirect={mepc_in[SIZE-1:2],2'b00}, captured at T.
- No FLUSH or COMMIT states, and trap_csr_we stays 0.

Other rules:
- Any exception or mret input while busy is ignored, because those instructions are being flushed.
- trap_csr_we and pc_redirect_valid are never high in the same cycle.
- trap_mepc/mcause/mtval and pc_redirect are 0 in IDLE after reset until the first event. Thereafter they hold their last value.
- busy=1 in FLUSH, COMMIT and REDIRECT.

Decomposition:
- Shared package trap_pkg holds:
  - the state encoding: IDLE=0, FLUSH=1, COMMIT=2, REDIRECT=3;
  - cause constants: CAUSE_IMISALIGN=0, CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_LMISALIGN=4, CAUSE_SMISALIGN=6, CAUSE_ECALL_M=11.
- Sub-module trap_prio_enc: a combinational priority encoder. It takes the six request bits plus ldst_is_store and produces valid, cause, and select codes for mepc and mtval.
- The FSM, counter and capture registers live in trap_ctrl.

Test Plan:
1. Reset then idle: all outputs 0, busy=0 for 10 cycles.
2. ecall with PC_exec=0x100, mtvec_address=0x203: flush at T; trap_csr_we at T+3 with mepc=0x100, mcause=11, mtval=0; redirect at T+4 to 0x200.
3. Misaligned load and illegal in the same cycle, with PC_MEM=0x40, PC_exec=0x44, ldst_address=0x1002, ldst_is_store=0: mepc=0x40, mcause=4, mtval=0x1002; illegal is dropped.
4. mret with mepc_in=0x87: flush at T; pc_redirect_valid at T+1 with target 0x84; trap_csr_we never asserted.
5. Misaligned jump (jump_address=0x302) then ecall asserted during FLUSH: only one sequence runs, with mcause=0, mtval=0x302; ecall ignored.
6. Reset asserted in COMMIT-1 (during FLUSH): no trap_csr_we, no redirect; state IDLE next cycle. Repeat with FLUSH_CYCLES=1 and check the redirect arrives at T+3.
